// File: rtl/dw_downsizer_arbiter.sv
// Round-robin arbiter that grants one wide word at a time from NUM_REQ requesters and
// serializes it onto a narrow DW_OUT stream, LSB slice first.
module dw_downsizer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW_IN   = 32,
    parameter int DW_OUT  = 8,
    localparam int NumSlots = DW_IN / DW_OUT,
    localparam int IdW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int SlotW    = (NumSlots > 1) ? $clog2(NumSlots) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_REQ-1:0][DW_IN-1:0]    din_i,
    input  logic [NUM_REQ-1:0]               vld_i,
    output logic [NUM_REQ-1:0]               rdy_o,
    output logic [DW_OUT-1:0]                dout_o,
    output logic                             vld_o,
    input  logic                             rdy_i,
    output logic [IdW-1:0]                   src_o,
    output logic                             last_o
);

    if ((NUM_REQ < 1) || (DW_OUT > DW_IN) || ((DW_IN % DW_OUT) != 0)) begin : g_bad_cfg
        $fatal(1, "dw_downsizer_arbiter: illegal NUM_REQ/DW_IN/DW_OUT combination");
    end

    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [DW_IN-1:0]     word_q, word_d;
    logic [SlotW-1:0]     slot_q, slot_d;
    logic [IdW-1:0]       src_q, src_d;
    logic [IdW-1:0]       rr_q, rr_d;
    logic [IdW-1:0]       win_s;
    logic [NUM_REQ-1:0]   gnt_s;
    logic                 any_s;
    logic                 last_s;
    logic                 acc_en_s;
    logic                 accept_s;

    // Round-robin search starting at rr_q, wrapping modulo NUM_REQ.
    always_comb begin : p_arb
        int idx;
        logic hit;
        gnt_s = '0;
        win_s = '0;
        any_s = 1'b0;
        idx   = 0;
        hit   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx        = ((int'(rr_q) + k) >= NUM_REQ) ? (int'(rr_q) + k - NUM_REQ) : (int'(rr_q) + k);
            hit        = ~any_s & vld_i[idx];
            gnt_s[idx] = hit;
            win_s      = hit ? IdW'(idx) : win_s;
            any_s      = any_s | hit;
        end
    end

    assign last_s   = (slot_q == SlotW'(NumSlots - 1));
    // A new word may load while the final slot of the current one is being handed off.
    assign acc_en_s = (state_q == IDLE) | ((state_q == SEND) & rdy_i & last_s);
    assign accept_s = any_s & acc_en_s;
    assign rdy_o    = gnt_s & {NUM_REQ{acc_en_s}};

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept_s ? SEND : IDLE;
            SEND:    state_d = (accept_s || !(rdy_i && last_s)) ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word buffer, slot counter, source and round-robin pointer updates.
    always_comb begin
        word_d = word_q;
        src_d  = src_q;
        slot_d = slot_q;
        rr_d   = rr_q;
        if (accept_s) begin
            word_d = din_i[win_s];
            src_d  = win_s;
            slot_d = '0;
            rr_d   = (int'(win_s) == (NUM_REQ - 1)) ? '0 : (win_s + IdW'(1));
        end else if ((state_q == SEND) && rdy_i && !last_s) begin
            slot_d = slot_q + SlotW'(1);
        end else begin
            slot_d = slot_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            src_q  <= '0;
            slot_q <= '0;
            rr_q   <= '0;
        end else begin
            word_q <= word_d;
            src_q  <= src_d;
            slot_q <= slot_d;
            rr_q   <= rr_d;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        vld_o  = (state_q == SEND);
        last_o = (state_q == SEND) & last_s;
        dout_o = word_q[int'(slot_q) * DW_OUT +: DW_OUT];
        src_o  = src_q;
    end

endmodule
